// File: rtl/eq_delay_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : eq_delay_checker_if
// Brief    : Harness-side bundle for eq_delay_checker: enable, spec/impl
//            channel buses and the comparison / first-failure results.
// Revision : 1.0  initial release
// ============================================================================
interface eq_delay_checker_if #(
    parameter int WIDTH = 8,
    parameter int CH    = 1,
    parameter int CNT_W = 16
);
    localparam int c_CH_W = (CH > 1) ? $clog2(CH) : 1;

    logic                  en;
    logic [WIDTH*CH-1:0]   s_out;
    logic [WIDTH*CH-1:0]   i_out;
    logic [CH-1:0]         mismatch;
    logic                  prop;
    logic                  fail_sticky;
    logic [CNT_W-1:0]      fail_cycle;
    logic [c_CH_W-1:0]     fail_ch;

    modport master (
        output en, s_out, i_out,
        input  mismatch, prop, fail_sticky, fail_cycle, fail_ch
    );

    modport slave (
        input  en, s_out, i_out,
        output mismatch, prop, fail_sticky, fail_cycle, fail_ch
    );
endinterface
`default_nettype wire

// File: rtl/eq_delay_checker.sv
`default_nettype none
// ============================================================================
// Module   : eq_delay_checker
// Brief    : Delays each spec channel by LAT enabled cycles and compares it
//            with the impl channel; reports mismatches and first failure.
//            Optional macro EQ_DELAY_CHECKER_ASSERT_EN adds assertions.
// Revision : 1.0  initial release
// ============================================================================
module eq_delay_checker #(
    parameter int WIDTH = 8,
    parameter int LAT   = 3,
    parameter int CH    = 1,
    parameter int CNT_W = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    eq_delay_checker_if.slave  bus
);
    localparam int                  c_CH_W     = (CH > 1) ? $clog2(CH) : 1;
    localparam int                  c_WARM_W   = $clog2(LAT + 1);
    localparam logic [c_WARM_W-1:0] c_WARM_MAX = c_WARM_W'(LAT);

    logic [c_WARM_W-1:0] r_warm;
    logic [CNT_W-1:0]    r_cyc;
    logic                r_fail_sticky;
    logic [CNT_W-1:0]    r_fail_cycle;
    logic [c_CH_W-1:0]   r_fail_ch;
    logic                w_armed;
    logic [CH-1:0]       w_mismatch;
    logic [c_CH_W-1:0]   w_first_ch;
    logic                w_prop;

    // Warm-up counts enabled cycles only, so stalls never shorten the latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_warm <= '0;
        end else if (bus.en && (r_warm != c_WARM_MAX)) begin
            r_warm <= r_warm + 1'b1;
        end
    end

    assign w_armed = (r_warm == c_WARM_MAX) && bus.en;

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            logic [WIDTH-1:0] r_dly [LAT];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < LAT; k++) r_dly[k] <= '0;
                end else if (bus.en) begin
                    r_dly[0] <= bus.s_out[c*WIDTH +: WIDTH];
                    for (int k = 1; k < LAT; k++) r_dly[k] <= r_dly[k-1];
                end
            end

            assign w_mismatch[c] = w_armed && (r_dly[LAT-1] != bus.i_out[c*WIDTH +: WIDTH]);
        end
    endgenerate

    assign w_prop = ~|w_mismatch;

    // Descending scan leaves the lowest mismatching index.
    always_comb begin
        w_first_ch = '0;
        for (int c = CH - 1; c >= 0; c--) begin
            if (w_mismatch[c]) w_first_ch = c_CH_W'(c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc <= '0;
        end else if (r_cyc != {CNT_W{1'b1}}) begin
            r_cyc <= r_cyc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fail_sticky <= 1'b0;
            r_fail_cycle  <= '0;
            r_fail_ch     <= '0;
        end else if (!w_prop && !r_fail_sticky) begin
            r_fail_sticky <= 1'b1;
            r_fail_cycle  <= r_cyc;
            r_fail_ch     <= w_first_ch;
        end
    end

    assign bus.mismatch    = w_mismatch;
    assign bus.prop        = w_prop;
    assign bus.fail_sticky = r_fail_sticky;
    assign bus.fail_cycle  = r_fail_cycle;
    assign bus.fail_ch     = r_fail_ch;

`ifdef EQ_DELAY_CHECKER_ASSERT_EN
    logic r_sticky_d;
    logic r_prop_prev_fail_clear;

    // Flags a sticky fail bit that dropped without a reset; never expected.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky_d             <= 1'b0;
            r_prop_prev_fail_clear <= 1'b0;
        end else begin
            r_sticky_d             <= r_fail_sticky;
            r_prop_prev_fail_clear <= r_sticky_d && !r_fail_sticky;
        end
    end

    a_prop: assert property (@(posedge clk) disable iff (reset) w_prop);
    a_sticky_consistent: assert property (@(posedge clk) disable iff (reset)
        !(r_fail_sticky && r_prop_prev_fail_clear));
`endif
endmodule
`default_nettype wire
